pipelined_barrel_shifter: RTL

- Parametrised, pipelined barrel shifter/rotator. Generalises the 16-bit combinational shifter to N = 2**C bits and five shift modes (including arithmetic right).
- One register stage per shift-amount bit, so it can sit on a long datapath without timing pressure.
- Valid/ready handshake with global backpressure and a pass-through tag for ordering checks.
- Sits between the ALU operand muxes and the writeback path.

---
 rtl/pipelined_barrel_shifter.sv | 95 +++++++++
 1 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter/rotator: C register stages, stage k applies a 2**k shift.
// Valid/ready flow control with global stall; a tag rides along with each operation.
module pipelined_barrel_shifter #(
  parameter int C  = 4,
  parameter int N  = 2**C,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  In,
  input  logic [C-1:0]  Cnt,
  input  logic [2:0]    Op,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  Out,
  output logic [TW-1:0] out_tag
);

  // Handshake: an operation transfers on a rising edge when in_valid && in_ready;
  // a result is consumed on a rising edge when out_valid && out_ready. The whole
  // pipe advances together (in_ready = !out_valid || out_ready) or holds together.

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  // One stage's worth of work; sh is always a power of two below N.
  function automatic logic [N-1:0] f_stage(input logic [N-1:0] d,
                                           input int unsigned   sh,
                                           input logic [2:0]    op,
                                           input logic          sgn);
    logic [N-1:0] ones;
    ones = '1;
    case (op)
      OP_ROL:  f_stage = (d << sh) | (d >> (N - sh));
      OP_SLL:  f_stage = d << sh;
      OP_ROR:  f_stage = (d >> sh) | (d << (N - sh));
      OP_SRL:  f_stage = d >> sh;
      OP_SRA:  f_stage = (d >> sh) | (sgn ? ~(ones >> sh) : '0);
      default: f_stage = d;
    endcase
  endfunction

  logic [N-1:0]  r_data  [C];
  logic [C-1:0]  r_cnt   [C];
  logic [2:0]    r_op    [C];
  logic [TW-1:0] r_tag   [C];
  logic          r_sign  [C];
  logic          r_valid [C];

  logic w_advance;

  assign w_advance = !r_valid[C-1] || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_valid[C-1];
  assign Out       = r_data[C-1];
  assign out_tag   = r_tag[C-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < C; k++) begin
        r_data[k]  <= '0;
        r_cnt[k]   <= '0;
        r_op[k]    <= '0;
        r_tag[k]   <= '0;
        r_sign[k]  <= 1'b0;
        r_valid[k] <= 1'b0;
      end
    end else if (w_advance) begin
      r_data[0]  <= Cnt[0] ? f_stage(In, 1, Op, In[N-1]) : In;
      r_cnt[0]   <= Cnt;
      r_op[0]    <= Op;
      r_tag[0]   <= in_tag;
      r_sign[0]  <= In[N-1];
      r_valid[0] <= in_valid;
      // The sign of the original operand travels with the op so later SRA stages fill correctly.
      for (int k = 1; k < C; k++) begin
        r_data[k]  <= r_cnt[k-1][k] ?
                      f_stage(r_data[k-1], 32'(1) << k, r_op[k-1], r_sign[k-1]) :
                      r_data[k-1];
        r_cnt[k]   <= r_cnt[k-1];
        r_op[k]    <= r_op[k-1];
        r_tag[k]   <= r_tag[k-1];
        r_sign[k]  <= r_sign[k-1];
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

endmodule
